signal_bram_capture_1k: RTL and testbench
=========================================

# signal_bram_capture_1k

Captures 1024 consecutive 14-bit signal samples into an inferred 1k block RAM after an arm command and a trigger event. A second read port lets the processor-side logic fetch the stored record. This is the recording counterpart of the BRAM signal playback block: a waveform captured here can be dumped to a .mem file and replayed unchanged. It sits between the ADC/filter output and the AXI/processor readout logic, in the same clock domain as the sample stream.

## Interface
Parameters:
- None. Data width is fixed at 14 bits and depth at 1024 words.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- ce  input  1  sample enable; one asserted cycle means one new valid sample.
- i14_signal  input  14  unsigned sample; valid when ce=1.
- i_arm  input  1  one-cycle arm command.
- i_trigger  input  1  external trigger; sampled only on ce cycles.
- i14_threshold  input  14  level-trigger threshold, unsigned. Used only with CAPTURE_LEVEL_TRIGGER_EN.
- i10_rd_addr  input  10  read-port address.
- o14_rd_data  output  14  read-port data.
- o_busy  output  1  high in ARMED or CAPTURE.
- o_done  output  1  high in DONE.
- o10_count  output  10  number of samples written in the current record, saturating at 1023 (see Operation).

## Operation
- Reset values: state IDLE; o_busy=0, o_done=0, o10_count=0, o14_rd_data=0, write index=0, level-trigger history register=0. Reset does not clear memory contents.
- FSM states and transitions:
  - IDLE: i_arm=1 -> ARMED.
  - ARMED: on a cycle with ce=1 and trig=1 -> CAPTURE. That same sample is written to address 0 and the index becomes 1.
  - CAPTURE: each ce=1 cycle writes i14_signal to mem[index] and increments the index. The write to address 1023 -> DONE.
  - DONE: i_arm=1 -> ARMED. In the same cycle, o_done clears and the index resets to 0.
- trig = i_trigger, or the level condition when the feature is enabled.
- i_arm is ignored in ARMED and CAPTURE; a capture cannot be restarted without reset.
- ce=0 cycles freeze the index and the FSM. A trigger with ce=0 is ignored.
- o10_count equals the write index in CAPTURE.
  - In DONE it holds 1023, which denotes the full record; o_done qualifies full.
  - In ARMED and IDLE it is 0.
- The read port is independent of the FSM and valid in every state.
  - Reads of addresses not yet written in the current record return the previous contents.
  - A read and a write to the same address in the same cycle return the old data (read-first).
- An asynchronous reset mid-capture returns the FSM to IDLE immediately. The partial record stays in memory.

## Timing
- i_arm at edge N -> o_busy=1 after edge N.
- Trigger sample at edge T -> mem[0] written at edge T. Sample k of the record is written at the k-th ce edge counting from T (k=0 at T).
- o_done rises after the edge that writes mem[1023], and o_busy falls in the same cycle.
- Minimum arm-to-done time: 1024 ce cycles after the trigger.
- Read latency: i10_rd_addr sampled at edge R -> o14_rd_data valid after edge R (one cycle, registered output, BRAM inferable).

## Configuration
- CAPTURE_LEVEL_TRIGGER_EN defined: adds an internal rising-crossing trigger.
  - A register holds the previous ce-qualified sample.
  - level = (prev < i14_threshold) && (i14_signal >= i14_threshold), evaluated only on ce cycles.
  - trig = i_trigger | level.
  - The history register updates on every ce cycle in every state. The first comparison after reset uses prev=0.
- Not defined: trig = i_trigger only. No history register; i14_threshold is unconnected and ignored.

## Test plan
- Reset and idle: hold rstn=0 -> all outputs 0. Release with ce toggling, no arm -> state stays IDLE, o_busy=0, no writes (check that mem[0] retains a preloaded value).
- Basic capture: arm; ce every cycle; i14_signal = ramp 0..; i_trigger pulse when ramp=100 -> mem[k]=100+k for k=0..1023. o_done rises exactly 1024 cycles after the trigger edge, and o10_count=1023.
- Sparse ce: ce every 3rd cycle, trigger on a ce cycle -> 1024 samples captured with no duplicates or gaps. A trigger asserted on a ce=0 cycle is ignored.
- Arm ignored while busy, and re-arm from DONE: pulse i_arm mid-capture -> no restart, index continues. Pulse i_arm in DONE -> o_done=0, o_busy=1 next cycle, and a new trigger overwrites from address 0.
- Reset mid-capture: assert rstn=0 asynchronously at index 500 -> o_busy=0 and o10_count=0 immediately. mem[0..499] is retained and readable with one-cycle latency.
- Level trigger (macro defined): threshold=8000; sine crossing upward -> first stored sample ≥ 8000 and the previous sample < 8000. A downward crossing does not trigger. Without the macro, the same stimulus does not trigger.

Source files
------------

// File: rtl/signal_bram_capture_1k.sv
`default_nettype none
// ============================================================================
// Module   : signal_bram_capture_1k
// Purpose  : After an arm command and a trigger, records 1024 consecutive
//            14-bit samples into an inferred BRAM. A read-first port
//            returns the stored record. The optional rising-crossing level
//            trigger is enabled by defining CAPTURE_LEVEL_TRIGGER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module signal_bram_capture_1k (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ce,
  input  logic [13:0] i14_signal,
  input  logic        i_arm,
  input  logic        i_trigger,
  input  logic [13:0] i14_threshold,
  input  logic [9:0]  i10_rd_addr,
  output logic [13:0] o14_rd_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [9:0]  o10_count
);

  localparam logic [9:0] LAST_ADDR = 10'd1023;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic        trig;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [13:0] mem [1024];
  logic [13:0] rd_data_q;

`ifdef CAPTURE_LEVEL_TRIGGER_EN
  logic [13:0] prev_q;

  // History follows the ce-qualified stream in every state, so a crossing
  // right after arming is judged against the true previous sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q <= '0;
    end else if (ce) begin
      prev_q <= i14_signal;
    end
  end

  assign trig = i_trigger | ((prev_q < i14_threshold) && (i14_signal >= i14_threshold));
`else
  logic unused_threshold;
  assign unused_threshold = ^i14_threshold;
  assign trig             = i_trigger;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    wr_addr = idx_q;
    case (state_q)
      S_IDLE: begin
        if (i_arm) begin
          state_d = S_ARMED;
          idx_d   = '0;
        end
      end
      S_ARMED: begin
        if (ce && trig) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          idx_d   = 10'd1;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (ce) begin
          wr_en   = 1'b1;
          wr_addr = idx_q;
          if (idx_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 10'd1;
          end
        end
      end
      S_DONE: begin
        if (i_arm) begin
          state_d = S_ARMED;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Memory has no reset so the record survives a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= i14_signal;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[i10_rd_addr];
    end
  end

  assign o14_rd_data = rd_data_q;
  assign o_busy      = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign o_done      = (state_q == S_DONE);
  assign o10_count   = (state_q == S_CAPTURE) ? idx_q :
                       (state_q == S_DONE)    ? LAST_ADDR : 10'd0;

endmodule
`default_nettype wire

// File: tb/tb_signal_bram_capture_1k.sv
`default_nettype none
// Bench for signal_bram_capture_1k: directed scenarios plus random traffic
// compared every cycle against a record-level behavioural model.
module tb_signal_bram_capture_1k;

  logic        clk     = 1'b0;
  logic        rstn    = 1'b0;
  logic        ce      = 1'b0;
  logic [13:0] sig     = '0;
  logic        arm     = 1'b0;
  logic        trg     = 1'b0;
  logic [13:0] thr     = 14'h3FFF;
  logic [9:0]  rd_addr = '0;
  logic [13:0] rd_data;
  logic        busy;
  logic        done;
  logic [9:0]  count;

  int n_chk  = 0;
  int n_fail = 0;
  bit run    = 1'b0;

  always #5 clk = ~clk;

  signal_bram_capture_1k dut (
    .clk          (clk),
    .rstn         (rstn),
    .ce           (ce),
    .i14_signal   (sig),
    .i_arm        (arm),
    .i_trigger    (trg),
    .i14_threshold(thr),
    .i10_rd_addr  (rd_addr),
    .o14_rd_data  (rd_data),
    .o_busy       (busy),
    .o_done       (done),
    .o10_count    (count)
  );

  // Model: a record is "armed" until it holds 1024 samples ("full").
  logic [13:0] m_mem   [1024];
  bit          m_known [1024];
  bit          m_armed;
  bit          m_full;
  int          m_n;
  logic [13:0] m_rd;
  bit          m_rd_known;
  logic        m_level;

`ifdef CAPTURE_LEVEL_TRIGGER_EN
  logic [13:0] m_prev;
  assign m_level = (m_prev < thr) && (sig >= thr);
`else
  assign m_level = 1'b0;
`endif

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_armed    <= 1'b0;
      m_full     <= 1'b0;
      m_n        <= 0;
      m_rd       <= '0;
      m_rd_known <= 1'b1;
`ifdef CAPTURE_LEVEL_TRIGGER_EN
      m_prev     <= '0;
`endif
    end else begin
      m_rd       <= m_mem[rd_addr];
      m_rd_known <= m_known[rd_addr];
`ifdef CAPTURE_LEVEL_TRIGGER_EN
      if (ce) m_prev <= sig;
`endif
      if (m_armed && !m_full) begin
        if (ce && (m_n > 0 || trg || m_level)) begin
          m_mem[m_n[9:0]]   <= sig;
          m_known[m_n[9:0]] <= 1'b1;
          m_n               <= m_n + 1;
          if (m_n == 1023) m_full <= 1'b1;
        end
      end else if (arm) begin
        m_armed <= 1'b1;
        m_full  <= 1'b0;
        m_n     <= 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("busy", int'(busy), int'(m_armed && !m_full));
      chk("done", int'(done), int'(m_full));
      chk("count", int'(count), m_full ? 1023 : (m_armed ? m_n : 0));
      if (m_rd_known) chk("rd_data", int'(rd_data), int'(m_rd));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_lit(input string name, input int a, input int e);
    rd_addr = a[9:0];
    cyc();
    chk(name, int'(rd_data), e);
  endtask

  logic [13:0] tab [64];

  initial begin
    int t;
    int v;
    int v0;
    int ncross;

    for (int n = 0; n < 64; n++)
      tab[n] = 14'(8192 + $rtoi(8000.0 * $cos(6.283185307179586 * n / 64.0)));
    ncross = -1;
    for (int n = 1; n < 64; n++)
      if (ncross < 0 && tab[n-1] < 14'd8000 && tab[n] >= 14'd8000) ncross = n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    run  = 1'b1;
    rstn = 1'b1;

    // Idle: ce toggling with triggers, never armed
    for (int i = 0; i < 20; i++) begin
      ce  = i[0];
      sig = 14'($urandom & 32'h1FFF);
      trg = (i == 5);
      cyc();
    end
    trg = 1'b0;
    chk("idle_busy", int'(busy), 0);

    // Basic ramp capture, with an ignored arm mid-capture
    ce = 1'b1; sig = '0; arm = 1'b1;
    cyc();
    arm = 1'b0;
    t = -1;
    for (int r = 0; r < 1300; r++) begin
      sig = r[13:0];
      trg = (r == 100);
      arm = (r == 600);
      cyc();
      if (done) begin t = r - 99; break; end
    end
    trg = 1'b0; arm = 1'b0; ce = 1'b0;
    chk("trig_to_done_edges", t, 1024);
    chk("done_count", int'(count), 1023);
    for (int k = 0; k < 1024; k++) begin
      rd_addr = k[9:0];
      cyc();
    end
    read_lit("basic_mem0", 0, 100);
    read_lit("basic_mem1", 1, 101);
    read_lit("basic_mem511", 511, 611);
    read_lit("basic_mem1023", 1023, 1123);

    // Reset from DONE, then idle traffic must not write
    rstn = 1'b0;
    cyc();
    chk("rst2_done", int'(done), 0);
    rstn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ce  = i[0];
      sig = 14'($urandom & 32'h1FFF);
      trg = (i % 7 == 0);
      cyc();
    end
    trg = 1'b0;
    read_lit("retain_mem0", 0, 100);
    chk("idle2_busy", int'(busy), 0);

    // Sparse ce, first trigger on a ce=0 cycle
    ce = 1'b0; arm = 1'b1;
    cyc();
    arm = 1'b0;
    v = 2000; v0 = -1; t = -1;
    for (int c = 0; c < 4000; c++) begin
      ce  = (c % 3 == 0);
      trg = (c == 4) || (c == 9);
      sig = v[13:0];
      if (ce && trg && v0 < 0) v0 = v;
      cyc();
      if (ce) v++;
      if (done) begin t = c; break; end
    end
    trg = 1'b0; ce = 1'b0;
    chk("sparse_done", int'(done), 1);
    read_lit("sparse_mem0", 0, 2003);
    read_lit("sparse_mem1", 1, v0 + 1);
    read_lit("sparse_mem1023", 1023, v0 + 1023);

    // Re-arm from DONE, then async reset at index 500
    arm = 1'b1;
    cyc();
    arm = 1'b0;
    chk("rearm_done", int'(done), 0);
    chk("rearm_busy", int'(busy), 1);
    ce = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sig = 14'($urandom & 32'h1FFF);
      cyc();
    end
    t = -1;
    for (int c = 0; c < 600; c++) begin
      sig = 14'(3000 + c);
      trg = (c == 0);
      cyc();
      if (count == 10'd500) begin t = c; break; end
    end
    trg = 1'b0;
    chk("mid_count_500", t, 499);
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_done", int'(done), 0);
    ce = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    read_lit("arst_mem0", 0, 3000);
    read_lit("arst_mem250", 250, 3250);
    read_lit("arst_mem499", 499, 3499);

    // Level trigger: sine starting at its peak, down then up through 8000
    thr = 14'd8000;
    ce = 1'b1; sig = 14'd16192;
    repeat (3) cyc();
    ce = 1'b0; arm = 1'b1;
    cyc();
    arm = 1'b0; ce = 1'b1;
    for (int n = 0; n < 100; n++) begin
      sig = tab[n % 64];
      cyc();
    end
`ifdef CAPTURE_LEVEL_TRIGGER_EN
    chk("lvl_count", int'(count), 100 - ncross);
`else
    chk("lvl_no_trig_busy", int'(busy), 1);
    chk("lvl_no_trig_count", int'(count), 0);
`endif
    for (int n = 100; n < 1300; n++) begin
      sig = tab[n % 64];
      trg = (n == 100);
      cyc();
      if (done) break;
    end
    trg = 1'b0; ce = 1'b0;
    chk("lvl_done", int'(done), 1);
`ifdef CAPTURE_LEVEL_TRIGGER_EN
    read_lit("lvl_mem0", 0, int'(tab[ncross]));
    chk("lvl_mem0_ge_thr", int'(rd_data >= 14'd8000), 1);
`else
    read_lit("lvl_mem0", 0, int'(tab[100 % 64]));
`endif

    // Random traffic
    for (int c = 0; c < 5000; c++) begin
      ce      = (($urandom % 4) != 0);
      sig     = 14'($urandom);
      trg     = (($urandom % 50) == 0);
      arm     = (($urandom % 300) == 0);
      rd_addr = 10'($urandom);
      thr     = 14'($urandom);
      rstn    = (c != 2500);
      cyc();
    end
    rstn = 1'b1; ce = 1'b0; trg = 1'b0; arm = 1'b0;
    cyc();

    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected completion before %0t", $time);
    $fatal(1, "bench did not complete");
  end

endmodule
`default_nettype wire
